stage_wb: RTL and testbench
===========================

// Module: stage_wb
// PURPOSE
// - Writeback stage of the RV32I pipeline, and the write-side counterpart of the decode-stage register file.
// - Accepts retiring instructions from MEM/WB and selects the writeback value.
// - Aligns and extends load data, then drives the regfile write port (load_regfile/rd/wb_data) for exactly one cycle per commit.
// - Holds the pipeline via valid/ready while a load waits for its data-memory response.
// PARAMETERS
// - XLEN  32  datapath width; only 32 is supported.
// PORTS
// - clk             in   1     clock; all state updates on posedge
// - rst_n           in   1     reset; asynchronous assert, active-low
// - in_valid        in   1     MEM/WB holds a retiring instruction
// - in_ready        out  1     stage can accept; transfer when in_valid&&in_ready
// - flush           in   1     kill the offered input this cycle; it is not accepted
// - in_ld_regfile   in   1     instruction writes rd
// - in_rd           in   5     destination register
// - in_wbmux_sel    in   3     wbmux_sel_t (package)
// - in_funct3       in   3     load width/sign (LB,LH,LW,LBU,LHU)
// - in_addr_lo      in   2     byte offset of load address
// - in_alu_out, in_u_imm, in_pc_plus4  in  32  candidate writeback values
// - in_br_en        in   1     compare result, zero-extended for SLT*
// - dmem_resp       in   1     data memory response strobe
// - dmem_rdata      in   32    raw aligned word from data memory
// - load_regfile    out  1     regfile write enable
// - rd              out  5     regfile write address
// - wb_data         out  32    regfile write data
// - busy            out  1     state != IDLE (hazard unit input)
// BEHAVIOUR
// - Reset: state=IDLE; load_regfile=0, rd=0, wb_data=0, busy=0; in_ready=1 once rst_n deasserts.
// - FSM states: IDLE, WAIT_RESP, COMMIT.
//   - IDLE: in_ready=1. On accept, the instruction is registered.
//     - Non-load -> COMMIT.
//     - Load with dmem_resp=1 in the same cycle -> capture dmem_rdata, then COMMIT.
//     - Load with dmem_resp=0 -> WAIT_RESP.
//   - WAIT_RESP: in_ready=0; busy=1. On dmem_resp, capture dmem_rdata -> COMMIT.
//   - COMMIT: load_regfile = ld_regfile && rd!=0 for this one cycle only. in_ready=1.
//     - Simultaneous accept is legal: same rules as IDLE, giving back-to-back commits.
//     - With no accept -> IDLE.
// - Latency:
//   - Non-load: accepted in cycle N -> written in cycle N+1.
//   - Load: written one cycle after the cycle in which dmem_resp is sampled high.
// - Sustained throughput is 1 instruction/cycle for non-loads.
// - Load extraction:
//   - Byte = rdata[8*addr_lo+:8]; half = rdata[16*addr_lo[1]+:16].
//   - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
//   - Misaligned half/word: addr_lo bits are ignored (no trap).
// - wbmux: ALU->alu_out, BR->{31'b0,br_en}, UIMM->u_imm, PC4->pc_plus4, LOAD->extracted.
//   - Unknown encodings -> alu_out.
// - rd==0 never asserts load_regfile. wb_data still updates.
// - flush only blocks acceptance. An instruction in WAIT_RESP/COMMIT is older than the flush and always commits.
// - dmem_resp in IDLE with no load accepted is ignored.
// - Reset mid-WAIT_RESP abandons the load; no write occurs.
// - wb_data/rd hold their last value when load_regfile=0.
// CONFIGURATION
// - STAGE_WB_RETIRE_CNT_EN defined: adds output retire_cnt[63:0].
//   - Reset 0; +1 on every COMMIT cycle, including rd==0 and ld_regfile=0.
//   - Wraps at 2^64.
// - Undefined: the port and the counter are absent; all other behaviour is identical.
// STRUCTURE
// - rv32i_types gets:
//   - wbmux_sel_t enum: ALU=0, BR=1, UIMM=2, PC4=3, LOAD=4.
//   - load_funct3_t enum.
//   - stage_wb_state_t enum.
// - Sub-module load_align (combinational): funct3, addr_lo, rdata -> 32-bit result. It is reusable by forwarding logic.
// TESTING
// - ALU op: alu_out=0x1234_5678, rd=5 -> cycle N+1: load_regfile=1, rd=5, wb_data=0x1234_5678; N+2: load_regfile=0.
// - LB: addr_lo=3, rdata=0x80FF_0000, dmem_resp 3 cycles late.
//   - in_ready=0 for 3 cycles, busy=1.
//   - Then wb_data=0xFFFF_FF80.
// - LHU: addr_lo=2, rdata=0x8001_0000, resp same cycle -> next cycle wb_data=0x0000_8001.
// - rd=0 with alu_out=0xDEAD_BEEF -> load_regfile stays 0. Back-to-back 4 ALU ops -> 4 consecutive write cycles.
// - flush with in_valid=1 -> no accept, no write. rst_n low during WAIT_RESP -> IDLE, no write, outputs 0.
// - With STAGE_WB_RETIRE_CNT_EN: 10 commits incl. 2 rd=0 -> retire_cnt=10.

Source files
------------

// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I enums for writeback mux select, load width and writeback FSM.
package rv32i_types;
    typedef enum logic [2:0] {
        WB_ALU  = 3'd0,
        WB_BR   = 3'd1,
        WB_UIMM = 3'd2,
        WB_PC4  = 3'd3,
        WB_LOAD = 3'd4
    } wbmux_sel_t;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RESP = 2'd1,
        COMMIT    = 2'd2
    } stage_wb_state_t;
endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/half from a memory word and sign/zero-extends it.
module load_align
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] result
);
    logic [7:0]  b;
    logic [15:0] h;

    assign b = rdata[8*addr_lo +: 8];
    assign h = rdata[16*addr_lo[1] +: 16];

    always_comb begin
        result = funct3 == LB  ? {{24{b[7]}}, b}  :
                 funct3 == LBU ? {24'b0, b}       :
                 funct3 == LH  ? {{16{h[15]}}, h} :
                 funct3 == LHU ? {16'b0, h}       : rdata;
    end
endmodule

// File: rtl/stage_wb.sv
// stage_wb: RV32I writeback stage; holds loads until the data response, then writes the regfile for one cycle.
// Optional STAGE_WB_RETIRE_CNT_EN adds a 64-bit retire counter output.
module stage_wb
    import rv32i_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic            in_ld_regfile,
    input  logic [4:0]      in_rd,
    input  wbmux_sel_t      in_wbmux_sel,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_addr_lo,
    input  logic [XLEN-1:0] in_alu_out,
    input  logic [XLEN-1:0] in_u_imm,
    input  logic [XLEN-1:0] in_pc_plus4,
    input  logic            in_br_en,
    input  logic            dmem_resp,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            load_regfile,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] wb_data,
    output logic            busy
`ifdef STAGE_WB_RETIRE_CNT_EN
    ,
    output logic [63:0]     retire_cnt
`endif
);
    stage_wb_state_t state, state_n;
    logic            accept, is_load, from_wait, ld_q, pend_ld;
    logic [4:0]      pend_rd;
    logic [2:0]      pend_f3;
    logic [1:0]      pend_lo;
    logic [XLEN-1:0] aligned, wb_n;

    assign in_ready     = state != WAIT_RESP;
    assign busy         = state != IDLE;
    assign accept       = in_valid && in_ready && !flush;
    assign is_load      = in_wbmux_sel == WB_LOAD;
    assign from_wait    = state == WAIT_RESP;
    assign load_regfile = state == COMMIT && ld_q && rd != 5'd0;

    // A waiting load aligns with its stored width/offset; otherwise the offered instruction's fields are used.
    load_align u_align (
        .funct3  (from_wait ? pend_f3 : in_funct3),
        .addr_lo (from_wait ? pend_lo : in_addr_lo),
        .rdata   (dmem_rdata),
        .result  (aligned)
    );

    always_comb begin
        state_n = from_wait ? (dmem_resp ? COMMIT : WAIT_RESP) :
                  accept    ? ((!is_load || dmem_resp) ? COMMIT : WAIT_RESP) : IDLE;
        wb_n    = (from_wait || is_load)   ? aligned :
                  in_wbmux_sel == WB_BR    ? {{(XLEN-1){1'b0}}, in_br_en} :
                  in_wbmux_sel == WB_UIMM  ? in_u_imm :
                  in_wbmux_sel == WB_PC4   ? in_pc_plus4 : in_alu_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ld_q    <= 1'b0;
            rd      <= '0;
            wb_data <= '0;
            pend_ld <= 1'b0;
            pend_rd <= '0;
            pend_f3 <= '0;
            pend_lo <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                pend_ld <= in_ld_regfile;
                pend_rd <= in_rd;
                pend_f3 <= in_funct3;
                pend_lo <= in_addr_lo;
            end
            if (state_n == COMMIT) begin
                ld_q    <= from_wait ? pend_ld : in_ld_regfile;
                rd      <= from_wait ? pend_rd : in_rd;
                wb_data <= wb_n;
            end
        end
    end

`ifdef STAGE_WB_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retire_cnt <= '0;
        else if (state == COMMIT) retire_cnt <= retire_cnt + 64'd1;
    end
`endif
endmodule

// File: tb/tb_stage_wb.sv
// tb_stage_wb: directed self-checking bench for stage_wb; inputs change and outputs are sampled on negedge.
module tb_stage_wb;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, flush, in_ld_regfile, in_br_en, dmem_resp;
    logic [4:0]  in_rd, rd;
    wbmux_sel_t  in_wbmux_sel;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_alu_out, in_u_imm, in_pc_plus4, dmem_rdata, wb_data;
    logic        load_regfile, busy;
`ifdef STAGE_WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
`endif
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stage_wb dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .in_ld_regfile(in_ld_regfile), .in_rd(in_rd), .in_wbmux_sel(in_wbmux_sel),
        .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .in_alu_out(in_alu_out),
        .in_u_imm(in_u_imm), .in_pc_plus4(in_pc_plus4), .in_br_en(in_br_en),
        .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata), .load_regfile(load_regfile),
        .rd(rd), .wb_data(wb_data), .busy(busy)
`ifdef STAGE_WB_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );

    task automatic offer(input wbmux_sel_t s, input logic [2:0] f3, input logic [1:0] lo,
                         input logic [31:0] alu, input logic [4:0] r);
        in_valid = 1'b1; in_ld_regfile = 1'b1; in_wbmux_sel = s; in_funct3 = f3;
        in_addr_lo = lo; in_alu_out = alu; in_rd = r;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; flush = 1'b0; in_ld_regfile = 1'b0; in_rd = '0; in_wbmux_sel = WB_ALU;
        in_funct3 = '0; in_addr_lo = '0; in_alu_out = '0; in_u_imm = '0; in_pc_plus4 = '0;
        in_br_en = 1'b0; dmem_resp = 1'b0; dmem_rdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        n_checks++;
        if (load_regfile !== 1'b0 || rd !== 5'd0 || wb_data !== 32'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ld=%b rd=%0d wb=%h busy=%b, want 0 0 0 0", load_regfile, rd, wb_data, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got in_ready=%b busy=%b, want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_alu();
        offer(WB_ALU, 3'd0, 2'd0, 32'h1234_5678, 5'd5);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (load_regfile !== 1'b1 || rd !== 5'd5 || wb_data !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL alu_write: got ld=%b rd=%0d wb=%h, want 1 5 12345678", load_regfile, rd, wb_data);
        end
        @(negedge clk);
        n_checks++;
        if (load_regfile !== 1'b0 || wb_data !== 32'h1234_5678 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_one_cycle: got ld=%b wb=%h busy=%b, want 0 12345678 0", load_regfile, wb_data, busy);
        end
    endtask

    task automatic test_lb_wait();
        offer(WB_LOAD, LB, 2'd3, 32'h0, 5'd7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            n_checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1 || load_regfile !== 1'b0) begin
                n_fail++;
                $display("FAIL lb_wait%0d: got in_ready=%b busy=%b ld=%b, want 0 1 0", i, in_ready, busy, load_regfile);
            end
        end
        dmem_resp = 1'b1; dmem_rdata = 32'h80FF_0000;
        @(negedge clk);
        dmem_resp = 1'b0; dmem_rdata = '0;
        n_checks++;
        if (load_regfile !== 1'b1 || rd !== 5'd7 || wb_data !== 32'hFFFF_FF80) begin
            n_fail++;
            $display("FAIL lb_commit: got ld=%b rd=%0d wb=%h, want 1 7 ffffff80", load_regfile, rd, wb_data);
        end
        @(negedge clk);
    endtask

    task automatic test_load_align();
        logic [2:0]  f3 [6] = '{LHU, LH, LW, LBU, LB, LH};
        logic [1:0]  lo [6] = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd1};
        logic [31:0] rv [6] = '{32'h8001_0000, 32'h8001_0000, 32'hCAFE_F00D, 32'h0000_F500, 32'h0000_007F, 32'h1234_9ABC};
        logic [31:0] ex [6] = '{32'h0000_8001, 32'hFFFF_8001, 32'hCAFE_F00D, 32'h0000_00F5, 32'h0000_007F, 32'hFFFF_9ABC};
        for (int i = 0; i < 6; i++) begin
            offer(WB_LOAD, f3[i], lo[i], 32'h0, 5'd9);
            dmem_resp = 1'b1; dmem_rdata = rv[i];
            @(negedge clk);
            idle_inputs();
            n_checks++;
            if (load_regfile !== 1'b1 || wb_data !== ex[i]) begin
                n_fail++;
                $display("FAIL load_align%0d: got ld=%b wb=%h, want 1 %h", i, load_regfile, wb_data, ex[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wbmux();
        wbmux_sel_t  s  [4] = '{WB_BR, WB_UIMM, WB_PC4, wbmux_sel_t'(3'd6)};
        logic [31:0] ex [4] = '{32'h0000_0001, 32'hABCD_E000, 32'h0000_1004, 32'h0BAD_CAFE};
        for (int i = 0; i < 4; i++) begin
            offer(s[i], 3'd0, 2'd0, 32'h0BAD_CAFE, 5'd11);
            in_br_en = 1'b1; in_u_imm = 32'hABCD_E000; in_pc_plus4 = 32'h0000_1004;
            @(negedge clk);
            idle_inputs();
            n_checks++;
            if (load_regfile !== 1'b1 || wb_data !== ex[i]) begin
                n_fail++;
                $display("FAIL wbmux%0d: got ld=%b wb=%h, want 1 %h", i, load_regfile, wb_data, ex[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_rd0();
        offer(WB_ALU, 3'd0, 2'd0, 32'hDEAD_BEEF, 5'd0);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (load_regfile !== 1'b0 || wb_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL rd0: got ld=%b wb=%h, want 0 deadbeef", load_regfile, wb_data);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        offer(WB_ALU, 3'd0, 2'd0, 32'hA000_0001, 5'd1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (load_regfile !== 1'b1 || rd !== 5'(i) || wb_data !== 32'hA000_0000 + 32'(i)) begin
                n_fail++;
                $display("FAIL b2b%0d: got ld=%b rd=%0d wb=%h, want 1 %0d %h", i, load_regfile, rd, wb_data, i, 32'hA000_0000 + 32'(i));
            end
            if (i < 4) offer(WB_ALU, 3'd0, 2'd0, 32'hA000_0001 + 32'(i), 5'(i + 1));
            else in_valid = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (load_regfile !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got ld=%b, want 0", load_regfile);
        end
    endtask

    task automatic test_flush_and_idle_resp();
        offer(WB_ALU, 3'd0, 2'd0, 32'h5555_5555, 5'd3);
        flush = 1'b1;
        @(negedge clk);
        idle_inputs();
        n_checks++;
        if (load_regfile !== 1'b0 || busy !== 1'b0 || wb_data !== 32'hA000_0004) begin
            n_fail++;
            $display("FAIL flush: got ld=%b busy=%b wb=%h, want 0 0 a0000004", load_regfile, busy, wb_data);
        end
        dmem_resp = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        idle_inputs();
        n_checks++;
        if (load_regfile !== 1'b0 || busy !== 1'b0 || wb_data !== 32'hA000_0004) begin
            n_fail++;
            $display("FAIL idle_resp: got ld=%b busy=%b wb=%h, want 0 0 a0000004", load_regfile, busy, wb_data);
        end
    endtask

    task automatic test_reset_wait();
        offer(WB_LOAD, LW, 2'd0, 32'h0, 5'd12);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (load_regfile !== 1'b0 || rd !== 5'd0 || wb_data !== 32'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wait: got ld=%b rd=%0d wb=%h busy=%b, want 0 0 0 0", load_regfile, rd, wb_data, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dmem_resp = 1'b1; dmem_rdata = 32'h1111_1111;
        @(negedge clk);
        idle_inputs();
        n_checks++;
        if (load_regfile !== 1'b0 || wb_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_wait_abandon: got ld=%b wb=%h, want 0 0", load_regfile, wb_data);
        end
    endtask

`ifdef STAGE_WB_RETIRE_CNT_EN
    task automatic test_retire_cnt();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer(WB_ALU, 3'd0, 2'd0, 32'(i), (i < 2) ? 5'd0 : 5'(i));
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (retire_cnt !== 64'd10) begin
            n_fail++;
            $display("FAIL retire_cnt: got %0d, want 10", retire_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_lb_wait();
        test_load_align();
        test_wbmux();
        test_rd0();
        test_back_to_back();
        test_flush_and_idle_resp();
        test_reset_wait();
`ifdef STAGE_WB_RETIRE_CNT_EN
        test_retire_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
